stage_tl: RTL and testbench

STAGE_TL -- requirements
Module: stage_tl

---
 rtl/stage_tl.sv | 180 ++++++++++++++++++
 tb/tb_stage_tl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stage_tl.sv
`default_nettype none
// ============================================================================
// Module      : stage_tl
// Description : EX-to-cache pipeline register with a fully-associative DTLB
//               lookup/refill and an ITLB write strobe toward fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_tl #(
    parameter int ENTRIES   = 4,
    parameter int PAGE_BITS = 12,
    parameter int THREAD_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [THREAD_W-1:0]     ex_thread,
    input  logic                    ex_isvalid,
    input  logic                    ex_itlb_miss,
    input  logic [31:0]             ex_pc,
    input  logic [31:0]             ex_data,
    input  logic [31:0]             ex_mul,
    input  logic [31:0]             ex_r2,
    input  logic [4:0]              ex_dst,
    input  logic                    ex_flag_mem,
    input  logic                    ex_flag_store,
    input  logic                    ex_flag_isbyte,
    input  logic                    ex_flag_mul,
    input  logic                    ex_flag_reg,
    input  logic                    ex_flag_jump,
    input  logic                    ex_flag_branch,
    input  logic                    ex_flag_iret,
    input  logic [1:0]              ex_flag_tlbwrite,
    input  logic                    vm_en,
    input  logic                    dc_stall,
    output logic                    tl_stall,
    output logic [THREAD_W-1:0]     dc_thread,
    output logic                    dc_isvalid,
    output logic                    dc_itlb_miss,
    output logic [31:0]             dc_pc,
    output logic [31:0]             dc_data,
    output logic [31:0]             dc_mul,
    output logic [31:0]             dc_r2,
    output logic [4:0]              dc_dst,
    output logic                    dc_flag_mem,
    output logic                    dc_flag_store,
    output logic                    dc_flag_isbyte,
    output logic                    dc_flag_mul,
    output logic                    dc_flag_reg,
    output logic                    dc_flag_jump,
    output logic                    dc_flag_branch,
    output logic                    dc_flag_iret,
    output logic [1:0]              dc_flag_tlbwrite,
    output logic [31:0]             dc_addr,
    output logic                    dc_dtlb_miss,
    output logic                    itlb_wr_en,
    output logic [31-PAGE_BITS:0]   itlb_wr_vpn,
    output logic [31-PAGE_BITS:0]   itlb_wr_ppn
);

    localparam int VPN_W = 32 - PAGE_BITS;
    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [1:0] c_tlbw_itlb = 2'd1;
    localparam logic [1:0] c_tlbw_dtlb = 2'd2;

    logic [ENTRIES-1:0] r_valid;
    logic [VPN_W-1:0]   r_vpn [ENTRIES];
    logic [VPN_W-1:0]   r_ppn [ENTRIES];
    logic [IDX_W-1:0]   r_ptr;

    logic [VPN_W-1:0]   w_vpn;
    logic [VPN_W-1:0]   w_new_ppn;
    logic               w_hit;
    logic [IDX_W-1:0]   w_hit_idx;
    logic [VPN_W-1:0]   w_hit_ppn;
    logic               w_accept;
    logic               w_tlbw_ok;
    logic               w_dtlb_wr;
    logic               w_itlb_wr;
    logic [IDX_W-1:0]   w_wr_idx;
    logic               w_dtlb_miss;
    logic [31:0]        w_addr;

    assign tl_stall  = dc_stall;
    assign w_accept  = !dc_stall;
    assign w_vpn     = ex_data[31:PAGE_BITS];
    assign w_new_ppn = ex_r2[VPN_W-1:0];

    // CAM search; refills never create duplicate VPNs, so at most one hit
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_hit_ppn = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (r_vpn[i] == w_vpn)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
                w_hit_ppn = r_ppn[i];
            end
        end
    end

    assign w_tlbw_ok   = w_accept & ex_isvalid & !ex_itlb_miss;
    assign w_dtlb_wr   = w_tlbw_ok & (ex_flag_tlbwrite == c_tlbw_dtlb);
    assign w_itlb_wr   = w_tlbw_ok & (ex_flag_tlbwrite == c_tlbw_itlb);
    assign w_wr_idx    = w_hit ? w_hit_idx : r_ptr;
    assign w_dtlb_miss = ex_isvalid & !ex_itlb_miss & ex_flag_mem & vm_en & !w_hit;
    assign w_addr      = (ex_flag_mem && vm_en && w_hit) ?
                         {w_hit_ppn, ex_data[PAGE_BITS-1:0]} : ex_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            dc_thread        <= '0;
            dc_isvalid       <= 1'b0;
            dc_itlb_miss     <= 1'b0;
            dc_pc            <= '0;
            dc_data          <= '0;
            dc_mul           <= '0;
            dc_r2            <= '0;
            dc_dst           <= '0;
            dc_flag_mem      <= 1'b0;
            dc_flag_store    <= 1'b0;
            dc_flag_isbyte   <= 1'b0;
            dc_flag_mul      <= 1'b0;
            dc_flag_reg      <= 1'b0;
            dc_flag_jump     <= 1'b0;
            dc_flag_branch   <= 1'b0;
            dc_flag_iret     <= 1'b0;
            dc_flag_tlbwrite <= '0;
            dc_addr          <= '0;
            dc_dtlb_miss     <= 1'b0;
            itlb_wr_en       <= 1'b0;
            itlb_wr_vpn      <= '0;
            itlb_wr_ppn      <= '0;
            r_valid          <= '0;
            r_ptr            <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_vpn[i] <= '0;
                r_ppn[i] <= '0;
            end
        end else begin
            itlb_wr_en <= w_itlb_wr;
            if (w_itlb_wr) begin
                itlb_wr_vpn <= w_vpn;
                itlb_wr_ppn <= w_new_ppn;
            end
            if (w_dtlb_wr) begin
                r_valid[w_wr_idx] <= 1'b1;
                r_vpn[w_wr_idx]   <= w_vpn;
                r_ppn[w_wr_idx]   <= w_new_ppn;
                if (!w_hit) begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
            if (w_accept) begin
                dc_thread        <= ex_thread;
                dc_isvalid       <= ex_isvalid;
                dc_itlb_miss     <= ex_itlb_miss;
                dc_pc            <= ex_pc;
                dc_data          <= ex_data;
                dc_mul           <= ex_mul;
                dc_r2            <= ex_r2;
                dc_dst           <= ex_dst;
                // A faulting instruction must not write memory or registers
                dc_flag_mem      <= ex_flag_mem & !ex_itlb_miss;
                dc_flag_store    <= ex_flag_store & !ex_itlb_miss & !w_dtlb_miss;
                dc_flag_reg      <= ex_flag_reg & !ex_itlb_miss & !w_dtlb_miss;
                dc_flag_isbyte   <= ex_flag_isbyte;
                dc_flag_mul      <= ex_flag_mul;
                dc_flag_jump     <= ex_flag_jump;
                dc_flag_branch   <= ex_flag_branch;
                dc_flag_iret     <= ex_flag_iret;
                dc_flag_tlbwrite <= ex_flag_tlbwrite;
                dc_addr          <= w_addr;
                dc_dtlb_miss     <= w_dtlb_miss;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_tl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_tl
// Description : Directed self-checking bench for stage_tl (ENTRIES=4, 4 KiB).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_tl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ex_thread;
    logic        ex_isvalid, ex_itlb_miss;
    logic [31:0] ex_pc, ex_data, ex_mul, ex_r2;
    logic [4:0]  ex_dst;
    logic        ex_flag_mem, ex_flag_store, ex_flag_isbyte, ex_flag_mul;
    logic        ex_flag_reg, ex_flag_jump, ex_flag_branch, ex_flag_iret;
    logic [1:0]  ex_flag_tlbwrite;
    logic        vm_en, dc_stall;
    logic        tl_stall;
    logic [1:0]  dc_thread;
    logic        dc_isvalid, dc_itlb_miss;
    logic [31:0] dc_pc, dc_data, dc_mul, dc_r2;
    logic [4:0]  dc_dst;
    logic        dc_flag_mem, dc_flag_store, dc_flag_isbyte, dc_flag_mul;
    logic        dc_flag_reg, dc_flag_jump, dc_flag_branch, dc_flag_iret;
    logic [1:0]  dc_flag_tlbwrite;
    logic [31:0] dc_addr;
    logic        dc_dtlb_miss;
    logic        itlb_wr_en;
    logic [19:0] itlb_wr_vpn, itlb_wr_ppn;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stage_tl #(.ENTRIES(4), .PAGE_BITS(12), .THREAD_W(2)) dut (
        .clk(clk), .rst(rst),
        .ex_thread(ex_thread), .ex_isvalid(ex_isvalid), .ex_itlb_miss(ex_itlb_miss),
        .ex_pc(ex_pc), .ex_data(ex_data), .ex_mul(ex_mul), .ex_r2(ex_r2), .ex_dst(ex_dst),
        .ex_flag_mem(ex_flag_mem), .ex_flag_store(ex_flag_store),
        .ex_flag_isbyte(ex_flag_isbyte), .ex_flag_mul(ex_flag_mul),
        .ex_flag_reg(ex_flag_reg), .ex_flag_jump(ex_flag_jump),
        .ex_flag_branch(ex_flag_branch), .ex_flag_iret(ex_flag_iret),
        .ex_flag_tlbwrite(ex_flag_tlbwrite), .vm_en(vm_en), .dc_stall(dc_stall),
        .tl_stall(tl_stall),
        .dc_thread(dc_thread), .dc_isvalid(dc_isvalid), .dc_itlb_miss(dc_itlb_miss),
        .dc_pc(dc_pc), .dc_data(dc_data), .dc_mul(dc_mul), .dc_r2(dc_r2), .dc_dst(dc_dst),
        .dc_flag_mem(dc_flag_mem), .dc_flag_store(dc_flag_store),
        .dc_flag_isbyte(dc_flag_isbyte), .dc_flag_mul(dc_flag_mul),
        .dc_flag_reg(dc_flag_reg), .dc_flag_jump(dc_flag_jump),
        .dc_flag_branch(dc_flag_branch), .dc_flag_iret(dc_flag_iret),
        .dc_flag_tlbwrite(dc_flag_tlbwrite), .dc_addr(dc_addr), .dc_dtlb_miss(dc_dtlb_miss),
        .itlb_wr_en(itlb_wr_en), .itlb_wr_vpn(itlb_wr_vpn), .itlb_wr_ppn(itlb_wr_ppn)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ex_thread = 2'd0; ex_isvalid = 1'b0; ex_itlb_miss = 1'b0;
        ex_pc = 32'h0; ex_data = 32'h0; ex_mul = 32'h0; ex_r2 = 32'h0; ex_dst = 5'd0;
        ex_flag_mem = 1'b0; ex_flag_store = 1'b0; ex_flag_isbyte = 1'b0; ex_flag_mul = 1'b0;
        ex_flag_reg = 1'b0; ex_flag_jump = 1'b0; ex_flag_branch = 1'b0; ex_flag_iret = 1'b0;
        ex_flag_tlbwrite = 2'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [31:0] addr);
        idle();
        ex_isvalid = 1'b1; ex_flag_mem = 1'b1; ex_flag_reg = 1'b1; ex_data = addr; ex_dst = 5'd3;
        step();
    endtask

    task automatic wr(input logic [1:0] kind, input logic [31:0] va, input logic [31:0] pa);
        idle();
        ex_isvalid = 1'b1; ex_flag_tlbwrite = kind; ex_data = va; ex_r2 = pa;
        step();
    endtask

    initial begin
        // Reset with busy inputs and a stall asserted: reset must still clear
        idle();
        vm_en = 1'b1; dc_stall = 1'b1; rst = 1'b1;
        ex_isvalid = 1'b1; ex_data = 32'hDEAD_BEEF; ex_flag_mem = 1'b1; ex_flag_reg = 1'b1;
        step(); step();
        chk("rst_isvalid", {31'd0, dc_isvalid}, 32'd0);
        chk("rst_data", dc_data, 32'h0);
        chk("rst_addr", dc_addr, 32'h0);
        chk("rst_flag_reg", {31'd0, dc_flag_reg}, 32'd0);
        chk("rst_itlb_en", {31'd0, itlb_wr_en}, 32'd0);
        rst = 1'b0; dc_stall = 1'b0;

        // Cold lookup misses; register writeback is squashed
        ld(32'h0000_3ABC);
        chk("cold_miss", {31'd0, dc_dtlb_miss}, 32'd1);
        chk("cold_reg", {31'd0, dc_flag_reg}, 32'd0);
        chk("cold_addr", dc_addr, 32'h0000_3ABC);
        chk("cold_dst", {27'd0, dc_dst}, 32'd3);
        chk("cold_mem", {31'd0, dc_flag_mem}, 32'd1);

        // Refill VPN 3 -> PPN 0x80, then translate
        wr(2'd2, 32'h0000_3000, 32'h0000_0080);
        chk("wr_addr_pass", dc_addr, 32'h0000_3000);
        chk("wr_no_miss", {31'd0, dc_dtlb_miss}, 32'd0);
        ld(32'h0000_3ABC);
        chk("hit_addr", dc_addr, 32'h0008_0ABC);
        chk("hit_miss", {31'd0, dc_dtlb_miss}, 32'd0);
        chk("hit_reg", {31'd0, dc_flag_reg}, 32'd1);

        // A memory op that also refills sees the pre-write table
        idle();
        ex_isvalid = 1'b1; ex_flag_mem = 1'b1; ex_flag_tlbwrite = 2'd2;
        ex_data = 32'h0000_7123; ex_r2 = 32'h0000_0011;
        step();
        chk("same_cyc_miss", {31'd0, dc_dtlb_miss}, 32'd1);
        ld(32'h0000_7123);
        chk("next_cyc_hit", dc_addr, 32'h0001_1123);

        // Store that misses loses its store flag
        idle();
        ex_isvalid = 1'b1; ex_flag_mem = 1'b1; ex_flag_store = 1'b1; ex_data = 32'h0000_5004;
        ex_mul = 32'h1234_5678;
        step();
        chk("st_miss_store", {31'd0, dc_flag_store}, 32'd0);
        chk("st_miss_mul", dc_mul, 32'h1234_5678);

        // vm_en=0 passes the address through even on a TLB hit
        vm_en = 1'b0;
        ld(32'h0000_3ABC);
        chk("phys_addr", dc_addr, 32'h0000_3ABC);
        chk("phys_nomiss", {31'd0, dc_dtlb_miss}, 32'd0);
        vm_en = 1'b1;

        // Reset discards all entries
        rst = 1'b1; step(); rst = 1'b0;
        ld(32'h0000_3ABC);
        chk("post_rst_miss", {31'd0, dc_dtlb_miss}, 32'd1);

        // Five refills into four slots: VPN1 evicted, pointer wraps to 1
        for (int v = 1; v <= 5; v++) wr(2'd2, 32'(v) << 12, 32'h100 + 32'(v));
        ld(32'h0000_1000);
        chk("evict_v1", {31'd0, dc_dtlb_miss}, 32'd1);
        ld(32'h0000_2010);
        chk("keep_v2", dc_addr, 32'h0010_2010);
        ld(32'h0000_5FFF);
        chk("keep_v5", dc_addr, 32'h0010_5FFF);
        wr(2'd2, 32'h0000_6000, 32'h0000_0106);
        ld(32'h0000_2000);
        chk("ptr1_evict_v2", {31'd0, dc_dtlb_miss}, 32'd1);
        ld(32'h0000_3000);
        chk("ptr1_keep_v3", dc_addr, 32'h0010_3000);

        // Rewrite of VPN 3 updates in place and leaves the pointer at 2
        wr(2'd2, 32'h0000_3000, 32'h0000_0099);
        ld(32'h0000_3456);
        chk("rewrite_ppn", dc_addr, 32'h0009_9456);
        wr(2'd2, 32'h0000_8000, 32'h0000_0108);
        ld(32'h0000_3000);
        chk("rewrite_ptr_v3", {31'd0, dc_dtlb_miss}, 32'd1);
        ld(32'h0000_4000);
        chk("rewrite_ptr_v4", dc_addr, 32'h0010_4000);
        ld(32'h0000_8ABC);
        chk("rewrite_v8", dc_addr, 32'h0010_8ABC);

        // Stall: outputs frozen, no refill until the stall drops
        dc_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle();
            ex_isvalid = 1'b1; ex_flag_tlbwrite = 2'd2;
            ex_data = 32'h0000_9000 + 32'(k); ex_r2 = 32'h0000_0109;
            #1;
            chk("stall_comb", {31'd0, tl_stall}, 32'd1);
            step();
            chk("stall_addr", dc_addr, 32'h0010_8ABC);
            chk("stall_data", dc_data, 32'h0000_8ABC);
        end
        dc_stall = 1'b0;
        ld(32'h0000_9123);
        chk("stall_no_wr", {31'd0, dc_dtlb_miss}, 32'd1);
        chk("unstall_comb", {31'd0, tl_stall}, 32'd0);

        // ITLB refill: one-cycle strobe, DTLB untouched
        wr(2'd1, 32'h0004_2000, 32'h0000_0007);
        chk("itlb_en", {31'd0, itlb_wr_en}, 32'd1);
        chk("itlb_vpn", {12'd0, itlb_wr_vpn}, 32'h0000_0042);
        chk("itlb_ppn", {12'd0, itlb_wr_ppn}, 32'h0000_0007);
        ld(32'h0004_2000);
        chk("itlb_pulse", {31'd0, itlb_wr_en}, 32'd0);
        chk("itlb_no_dtlb", {31'd0, dc_dtlb_miss}, 32'd1);

        // Invalid slot refill is ignored and never flags a miss
        idle();
        ex_flag_tlbwrite = 2'd2; ex_flag_mem = 1'b1; ex_data = 32'h0000_A000; ex_r2 = 32'h0A;
        step();
        chk("inv_nomiss", {31'd0, dc_dtlb_miss}, 32'd0);
        ld(32'h0000_A000);
        chk("inv_no_wr", {31'd0, dc_dtlb_miss}, 32'd1);

        // ITLB fault: no side effects, no DTLB miss, no refill
        idle();
        ex_isvalid = 1'b1; ex_itlb_miss = 1'b1; ex_flag_mem = 1'b1; ex_flag_store = 1'b1;
        ex_flag_reg = 1'b1; ex_flag_tlbwrite = 2'd2; ex_data = 32'h0000_B000; ex_r2 = 32'h0B;
        step();
        chk("ifault_mem", {31'd0, dc_flag_mem}, 32'd0);
        chk("ifault_store", {31'd0, dc_flag_store}, 32'd0);
        chk("ifault_miss", {31'd0, dc_dtlb_miss}, 32'd0);
        chk("ifault_flag", {31'd0, dc_itlb_miss}, 32'd1);
        ld(32'h0000_B000);
        chk("ifault_no_wr", {31'd0, dc_dtlb_miss}, 32'd1);

        idle();
        step();
        chk("idle_valid", {31'd0, dc_isvalid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
